// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions used by the instruction fetch stage and its neighbours.
package fetch_stage_pkg;

    localparam int unsigned XLEN = 32;

    // Instruction word loaded into the IF/DOF register for a bubble.
    localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

    // Branch select from EX.
    typedef enum logic [1:0] {
        BS_NONE   = 2'b00,
        BS_COND   = 2'b01,
        BS_UNCOND = 2'b10,
        BS_JUMP   = 2'b11
    } bs_e;

    // Fetch FSM: one boot cycle after reset, then run until the next reset.
    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    // IF/DOF pipeline register payload.
    typedef struct packed {
        logic [XLEN-1:0] ir;
        logic [XLEN-1:0] pc_1;
        logic            valid;
    } ifdof_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus: EX redirect, hazard stall, instruction memory and IF/DOF outputs.
interface fetch_stage_if
    import fetch_stage_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 16
) ();

    logic                 stall;
    bs_e                  BS;
    logic                 PS;
    logic                 Z;
    logic [XLEN-1:0]      BrA;
    logic [XLEN-1:0]      RAA;
    logic [XLEN-1:0]      imem_data;
    logic                 imem_ready;
    logic [XLEN-1:0]      imem_addr;
    logic [XLEN-1:0]      IR_out;
    logic [XLEN-1:0]      PC_1_out;
    logic                 valid_out;
    logic                 squash;
    logic [CNT_WIDTH-1:0] bubble_cnt;

    // Fetch stage side.
    modport master (
        input  stall, BS, PS, Z, BrA, RAA, imem_data, imem_ready,
        output imem_addr, IR_out, PC_1_out, valid_out, squash, bubble_cnt
    );

    // Pipeline / memory side.
    modport slave (
        output stall, BS, PS, Z, BrA, RAA, imem_data, imem_ready,
        input  imem_addr, IR_out, PC_1_out, valid_out, squash, bubble_cnt
    );

endinterface

// File: rtl/fetch_next_pc.sv
// Redirect resolution and sequential PC increment for the fetch stage.
module fetch_next_pc
    import fetch_stage_pkg::*;
(
    input  logic [XLEN-1:0] pc_i,
    input  bs_e             bs_i,
    input  logic            ps_i,
    input  logic            z_i,
    input  logic [XLEN-1:0] bra_i,
    input  logic [XLEN-1:0] raa_i,
    output logic            taken_o,
    output logic [XLEN-1:0] target_o,
    output logic [XLEN-1:0] pc_plus1_o
);

    // Conditional branch taken when Z differs from the polarity bit.
    assign taken_o = ((bs_i == BS_COND) && (z_i ^ ps_i))
                   || (bs_i == BS_UNCOND)
                   || (bs_i == BS_JUMP);

    // Register jumps use RAA, all branches use BrA.
    assign target_o = (bs_i == BS_JUMP) ? raa_i : bra_i;

    // Modulo-2^32 increment; wrap is silent.
    assign pc_plus1_o = pc_i + XLEN'(1);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/DOF pipeline register and bubble counter.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned     CNT_WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);

    localparam ifdof_t BUBBLE = '{ir: NOP_WORD, pc_1: '0, valid: 1'b0};

    fetch_state_e         state_q, state_d;
    logic [XLEN-1:0]      pc_q, pc_d;
    ifdof_t               ifdof_q, ifdof_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                 taken_c;
    logic [XLEN-1:0]      target_c;
    logic [XLEN-1:0]      pc_plus1_c;
    logic [CNT_WIDTH-1:0] cnt_inc_c;

    fetch_next_pc u_next_pc (
        .pc_i       (pc_q),
        .bs_i       (bus.BS),
        .ps_i       (bus.PS),
        .z_i        (bus.Z),
        .bra_i      (bus.BrA),
        .raa_i      (bus.RAA),
        .taken_o    (taken_c),
        .target_o   (target_c),
        .pc_plus1_o (pc_plus1_c)
    );

    // Bubble counter sticks at all-ones.
    assign cnt_inc_c = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);

    // Next-state: redirect beats stall beats memory wait beats sequential fetch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ifdof_d = ifdof_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
                pc_d    = RESET_PC;
                ifdof_d = BUBBLE;
            end
            RUN: begin
                if (taken_c) begin
                    pc_d    = target_c;
                    ifdof_d = BUBBLE;
                    cnt_d   = cnt_inc_c;
                end else if (bus.stall) begin
                    pc_d    = pc_q;
                end else if (!bus.imem_ready) begin
                    ifdof_d = BUBBLE;
                    cnt_d   = cnt_inc_c;
                end else begin
                    pc_d    = pc_plus1_c;
                    ifdof_d = '{ir: bus.imem_data, pc_1: pc_plus1_c, valid: 1'b1};
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // State and pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            ifdof_q <= BUBBLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ifdof_q <= ifdof_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.imem_addr  = pc_q;
    assign bus.IR_out     = ifdof_q.ir;
    assign bus.PC_1_out   = ifdof_q.pc_1;
    assign bus.valid_out  = ifdof_q.valid;
    assign bus.bubble_cnt = cnt_q;
    // Redirects only act once the pipeline is running.
    assign bus.squash     = taken_c && (state_q == RUN);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a scoreboard of per-cycle expected IF/DOF state.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    typedef struct {
        int          tag;
        logic [31:0] addr;
        logic [31:0] ir;
        logic [31:0] pc1;
        logic        v;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst2_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   tag = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    fetch_stage_if #(.CNT_WIDTH(16)) bus ();
    fetch_stage_if #(.CNT_WIDTH(2))  bus2 ();

    fetch_stage #(.RESET_PC(32'h0), .CNT_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    fetch_stage #(.RESET_PC(32'h0), .CNT_WIDTH(2)) dut_sat (
        .clk   (clk),
        .rst_n (rst2_n),
        .bus   (bus2)
    );

    // Memory image: mem[a] = a*16.
    assign bus.imem_data = {bus.imem_addr[27:0], 4'h0};

    // Second instance sits in permanent memory wait to exercise saturation.
    assign bus2.stall      = 1'b0;
    assign bus2.BS         = BS_NONE;
    assign bus2.PS         = 1'b0;
    assign bus2.Z          = 1'b0;
    assign bus2.BrA        = 32'h0;
    assign bus2.RAA        = 32'h0;
    assign bus2.imem_data  = 32'h0;
    assign bus2.imem_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check squash, queue the post-edge expectation.
    task automatic step(input logic st, input bs_e bs, input logic ps, input logic z,
                        input logic [31:0] tgt, input logic rdy, input logic e_sq,
                        input logic [31:0] e_addr, input logic [31:0] e_ir,
                        input logic [31:0] e_pc1, input logic e_v, input logic [15:0] e_cnt);
        exp_t e;
        @(negedge clk);
        tag++;
        bus.stall      = st;
        bus.BS         = bs;
        bus.PS         = ps;
        bus.Z          = z;
        bus.BrA        = (bs == BS_JUMP) ? 32'hDEAD_0000 : tgt;
        bus.RAA        = (bs == BS_JUMP) ? tgt : 32'hBEEF_0000;
        bus.imem_ready = rdy;
        #1;
        chk($sformatf("c%0d.squash", tag), 32'(bus.squash), 32'(e_sq));
        e = '{tag: tag, addr: e_addr, ir: e_ir, pc1: e_pc1, v: e_v, cnt: e_cnt};
        sb.push_back(e);
    endtask

    // Monitor: after every edge, compare outputs against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk($sformatf("c%0d.imem_addr", e.tag), bus.imem_addr, e.addr);
                chk($sformatf("c%0d.IR_out", e.tag), bus.IR_out, e.ir);
                chk($sformatf("c%0d.PC_1_out", e.tag), bus.PC_1_out, e.pc1);
                chk($sformatf("c%0d.valid_out", e.tag), 32'(bus.valid_out), 32'(e.v));
                chk($sformatf("c%0d.bubble_cnt", e.tag), 32'(bus.bubble_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
        $fatal(1);
    end

    task automatic chk_reset(input string pfx);
        chk({pfx, ".imem_addr"}, bus.imem_addr, 32'h0);
        chk({pfx, ".IR_out"}, bus.IR_out, NOP_WORD);
        chk({pfx, ".PC_1_out"}, bus.PC_1_out, 32'h0);
        chk({pfx, ".valid_out"}, 32'(bus.valid_out), 32'h0);
        chk({pfx, ".bubble_cnt"}, 32'(bus.bubble_cnt), 32'h0);
        chk({pfx, ".squash"}, 32'(bus.squash), 32'h0);
    endtask

    initial begin
        bus.stall      = 1'b0;
        bus.BS         = BS_NONE;
        bus.PS         = 1'b0;
        bus.Z          = 1'b0;
        bus.BrA        = 32'h0;
        bus.RAA        = 32'h0;
        bus.imem_ready = 1'b1;

        #3;
        chk_reset("rst0");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // st bs ps z target rdy | squash addr ir pc1 v cnt
        step(0, BS_UNCOND, 0, 0, 32'h99, 1,   0, 32'h0, 32'h0, 32'h0, 0, 16'd0);
        step(0, BS_NONE,   0, 0, 32'h0,  1,   0, 32'h1, 32'h0, 32'h1, 1, 16'd0);
        step(0, BS_NONE,   0, 0, 32'h0,  1,   0, 32'h2, 32'h10, 32'h2, 1, 16'd0);
        step(0, BS_NONE,   0, 0, 32'h0,  1,   0, 32'h3, 32'h20, 32'h3, 1, 16'd0);
        step(0, BS_NONE,   0, 0, 32'h0,  1,   0, 32'h4, 32'h30, 32'h4, 1, 16'd0);
        step(0, BS_NONE,   0, 0, 32'h0,  1,   0, 32'h5, 32'h40, 32'h5, 1, 16'd0);
        // Unconditional branch at PC=5.
        step(0, BS_UNCOND, 0, 0, 32'h40, 1,   1, 32'h40, 32'h0, 32'h0, 0, 16'd1);
        step(0, BS_NONE,   0, 0, 32'h0,  1,   0, 32'h41, 32'h400, 32'h41, 1, 16'd1);
        // Conditional branch polarity.
        step(0, BS_COND,   0, 0, 32'h100, 1,  0, 32'h42, 32'h410, 32'h42, 1, 16'd1);
        step(0, BS_COND,   0, 1, 32'h100, 1,  1, 32'h100, 32'h0, 32'h0, 0, 16'd2);
        step(0, BS_JUMP,   0, 0, 32'h1234, 1, 1, 32'h1234, 32'h0, 32'h0, 0, 16'd3);
        step(0, BS_COND,   1, 1, 32'h100, 1,  0, 32'h1235, 32'h12340, 32'h1235, 1, 16'd3);
        step(0, BS_COND,   1, 0, 32'h7,   1,  1, 32'h7, 32'h0, 32'h0, 0, 16'd4);
        step(0, BS_NONE,   0, 0, 32'h0,   1,  0, 32'h8, 32'h70, 32'h8, 1, 16'd4);
        // Stall at PC=8, including a cycle with memory not ready.
        step(1, BS_NONE,   0, 0, 32'h0,   1,  0, 32'h8, 32'h70, 32'h8, 1, 16'd4);
        step(1, BS_NONE,   0, 0, 32'h0,   1,  0, 32'h8, 32'h70, 32'h8, 1, 16'd4);
        step(1, BS_NONE,   0, 0, 32'h0,   0,  0, 32'h8, 32'h70, 32'h8, 1, 16'd4);
        // Redirect overrides stall.
        step(1, BS_UNCOND, 0, 0, 32'h20,  1,  1, 32'h20, 32'h0, 32'h0, 0, 16'd5);
        // Two memory wait states.
        step(0, BS_NONE,   0, 0, 32'h0,   0,  0, 32'h20, 32'h0, 32'h0, 0, 16'd6);
        step(0, BS_NONE,   0, 0, 32'h0,   0,  0, 32'h20, 32'h0, 32'h0, 0, 16'd7);
        step(0, BS_NONE,   0, 0, 32'h0,   1,  0, 32'h21, 32'h200, 32'h21, 1, 16'd7);
        // PC wrap at the top of the address space.
        step(0, BS_UNCOND, 0, 0, 32'hFFFF_FFFF, 1, 1, 32'hFFFF_FFFF, 32'h0, 32'h0, 0, 16'd8);
        step(0, BS_NONE,   0, 0, 32'h0,   1,  0, 32'h0, 32'hFFFF_FFF0, 32'h0, 1, 16'd8);
        step(0, BS_NONE,   0, 0, 32'h0,   1,  0, 32'h1, 32'h0, 32'h1, 1, 16'd8);

        // Reset asserted in the middle of a redirect cycle.
        @(negedge clk);
        bus.BS  = BS_UNCOND;
        bus.BrA = 32'h50;
        #1;
        chk("midrst.squash_before", 32'(bus.squash), 32'h1);
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        @(posedge clk);
        #1;
        chk_reset("midrst_held");
        bus.BS = BS_NONE;
        rst_n  = 1'b1;
        step(0, BS_NONE,   0, 0, 32'h0,   1,  0, 32'h0, 32'h0, 32'h0, 0, 16'd0);
        step(0, BS_NONE,   0, 0, 32'h0,   1,  0, 32'h1, 32'h0, 32'h1, 1, 16'd0);

        @(posedge clk);
        #2;
        chk("sb_drain", 32'(sb.size()), 32'h0);

        // Saturation with a 2-bit counter: five bubbles end at 3.
        chk("sat.reset", 32'(bus2.bubble_cnt), 32'h0);
        rst2_n = 1'b1;
        @(posedge clk);
        #1;
        chk("sat.boot", 32'(bus2.bubble_cnt), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("sat.two", 32'(bus2.bubble_cnt), 32'h2);
        repeat (3) @(posedge clk);
        #1;
        chk("sat.five", 32'(bus2.bubble_cnt), 32'h3);
        chk("sat.addr", bus2.imem_addr, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction Fetch (IF) stage and IF/DOF pipeline register of the 32-bit RISC pipeline. Holds the PC, addresses instruction memory, forms PC+1, and registers the instruction word and PC+1 for the Decode and Operand Fetch stage, where PC+1 becomes the MA=1 operand for JML. Applies branch/jump redirects resolved in EX, stalls from the hazard unit, and instruction-memory wait states, inserting bubbles as required.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_WORD, 32'h0000_0000, instruction word placed in IR_out for a bubble
- CNT_WIDTH, 16, width of the saturating bubble counter
- clk  in  1  single system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hazard-unit stall: hold PC and IF/DOF register
- BS  in  2  branch select from EX: 00 none, 01 conditional to BrA, 10 unconditional to BrA, 11 jump to RAA
- PS  in  1  condition polarity for BS=01 (0: take if Z=1; 1: take if Z=0)
- Z  in  1  zero flag from EX
- BrA  in  32  branch target from EX
- RAA  in  32  register jump target from EX
- imem_data  in  32  instruction word at imem_addr
- imem_ready  in  1  imem_data valid this cycle
- imem_addr  out  32  instruction address (= PC)
- IR_out  out  32  registered instruction to DOF
- PC_1_out  out  32  registered PC+1 of that instruction to DOF
- valid_out  out  1  IR_out/PC_1_out hold a real instruction
- squash  out  1  combinational: redirect taken this cycle; DOF/EX register must bubble
- bubble_cnt  out  CNT_WIDTH  saturating count of bubbles inserted

## Operation
- FSM states: BOOT, RUN. Reset -> BOOT. BOOT -> RUN on first clock edge after rst_n rises, unconditionally. RUN is terminal until reset.
- BOOT: PC holds RESET_PC, IF/DOF loads bubble, bubble_cnt unchanged (boot bubble not counted).
- taken = (BS==01 & (Z^PS)) | BS==10 | BS==11; target = RAA when BS==11 else BrA. squash = taken & (state==RUN).
- RUN, per edge, priority order:
  1. taken: PC <- target; IF/DOF <- bubble; bubble_cnt++. Overrides stall and imem_ready.
  2. stall: PC, IR_out, PC_1_out, valid_out hold; bubble_cnt unchanged.
  3. !imem_ready: PC holds; IF/DOF <- bubble; bubble_cnt++.
  4. otherwise: PC <- PC+1; IR_out <- imem_data; PC_1_out <- PC+1; valid_out <- 1.
- Bubble: IR_out <- NOP_WORD, PC_1_out <- 0, valid_out <- 0.
- PC+1 is 32-bit modulo: 32'hFFFF_FFFF+1 = 0, no flag.
- bubble_cnt saturates at all-ones; never wraps.
- No branch delay slot: wrong-path instruction in IF is discarded by the bubble; DOF instruction is killed by squash downstream.

## Timing
- Reset (async assert, immediate): PC=RESET_PC, imem_addr=RESET_PC, IR_out=NOP_WORD, PC_1_out=0, valid_out=0, bubble_cnt=0, state=BOOT; squash=0.
- Reset deassertion synchronous to clk internally; first real fetch at RESET_PC occurs on the second edge after rst_n rises (BOOT edge, then RUN edge).
- Fetch latency: instruction at address A appears on IR_out with PC_1_out=A+1 one edge after imem_addr=A with imem_ready=1.
- Redirect: target on imem_addr the cycle after taken; target instruction valid on IR_out one edge later (one bubble per redirect).
- imem_ready low for N cycles: N bubbles, PC unchanged; fetch resumes without replay.
- Reset mid-operation: all state returns to reset values immediately regardless of stall/taken.

## Structure
- Shared CPU package: BS encodings (BS_NONE, BS_COND, BS_UNCOND, BS_JUMP), NOP_WORD constant, FSM state typedef.
- One sub-module natural: fetch_next_pc (combinational taken/target/PC+1 select); register and FSM logic stay in fetch_stage.

## Test plan
- Reset release, imem_ready=1, memory[i]=i*16: valid_out=0 first post-reset cycle, then IR_out=0,10,20… with PC_1_out=1,2,3…; bubble_cnt=0.
- In RUN at PC=5, BS=10, BrA=32'h40: squash=1, next imem_addr=32'h40, valid_out=0, bubble_cnt=1; next edge IR_out=mem[0x40], PC_1_out=32'h41.
- BS=01, PS=0 with Z=0 -> not taken, sequential; Z=1 -> taken; PS=1 inverts; BS=11, RAA=32'h1234 -> imem_addr=32'h1234.
- stall=1 for 3 cycles at PC=8: IR_out/PC_1_out/valid_out and imem_addr=8 frozen; same cycle stall and BS=10 -> redirect wins.
- imem_ready=0 for 2 cycles: 2 bubbles, PC held, bubble_cnt+=2; CNT_WIDTH=2 run of 5 bubbles saturates at 3.
- PC=32'hFFFF_FFFF fetch: PC_1_out=0, next imem_addr=0; rst_n pulsed low mid-redirect: outputs to reset values immediately.
